// File: rtl/load_store_unit_if.sv
// Command, data-memory and response signals of the load/store unit.
// The unit itself uses the slave view; the core/memory environment uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment/memop, drives byte lanes
// on a word-wide memory port, and returns extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

  state_e      state_q;
  logic        req_ready_q, mem_req_q, mem_we_q, resp_valid_q, resp_err_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q, mem_wdata_q, resp_rdata_q;
  logic [2:0]  memop_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  cnt_q;

  logic        is_half, is_word, err_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, ext_d;
  logic        tmo;

  // Decode of the command presented in IDLE.
  always_comb begin
    is_half = (bus.req_memop == 3'b001) || (!bus.req_we && bus.req_memop == 3'b100);
    is_word = (bus.req_memop == 3'b010);
    err_d   = (bus.req_we ? (bus.req_memop > 3'b010) : (bus.req_memop > 3'b100))
            || (is_half && bus.req_addr[0])
            || (is_word && (bus.req_addr[1:0] != 2'b00));
    if (is_word) begin
      be_d    = 4'b1111;
      wdata_d = bus.req_wdata;
    end else if (is_half) begin
      be_d    = 4'b0011 << bus.req_addr[1:0];
      wdata_d = {2{bus.req_wdata[15:0]}};
    end else begin
      be_d    = 4'b0001 << bus.req_addr[1:0];
      wdata_d = {4{bus.req_wdata[7:0]}};
    end
  end

  // Lane select and extension of the returned read word.
  always_comb begin
    shifted = bus.mem_rdata >> {addr_lo_q, 3'b000};
    case (memop_q)
      3'b000:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b011:  ext_d = {24'h0, shifted[7:0]};
      3'b100:  ext_d = {16'h0, shifted[15:0]};
      default: ext_d = bus.mem_rdata;
    endcase
  end

  assign tmo = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      memop_q      <= 3'b0;
      addr_lo_q    <= 2'b0;
      cnt_q        <= 8'h0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          req_ready_q <= 1'b0;
          memop_q     <= bus.req_memop;
          addr_lo_q   <= bus.req_addr[1:0];
          mem_we_q    <= bus.req_we;
          mem_be_q    <= be_d;
          mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
          mem_wdata_q <= wdata_d;
          cnt_q       <= 8'h0;
          if (err_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= cnt_q + 8'd1;
            if (mem_we_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q <= WAIT_R;
            end
          end else if (tmo) begin
            mem_req_q    <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
            cnt_q        <= 8'h0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT_R: begin
          if (bus.mem_rvalid || tmo) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !bus.mem_rvalid;
            resp_rdata_q <= bus.mem_rvalid ? ext_d : 32'h0;
            cnt_q        <= 8'h0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, error paths, timeout, mid-flight reset.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_memop = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Store with grant in the first REQ cycle; response lands in the cycle after.
  task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] mwd);
    issue(1'b1, op, a, wd);
    chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd1);
    chk({tag, " mem_be"}, 32'(bus.mem_be), 32'(be));
    chk({tag, " mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    chk({tag, " mem_wdata"}, bus.mem_wdata, mwd);
    chk({tag, " ready_busy"}, 32'(bus.req_ready), 32'd0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, " req_dropped"}, 32'(bus.mem_req), 32'd0);
    tick();
    chk({tag, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Load with grant in the first REQ cycle and rvalid one cycle later.
  // A stray rvalid with garbage data alongside the grant must be ignored.
  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, op, a, 32'h0);
    chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5A5A5A5A;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk({tag, " wait_no_resp"}, 32'(bus.resp_valid), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " resp_rdata"}, bus.resp_rdata, exp);
    chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    tick();
  endtask

  // Rejected command: response in the cycle right after accept, no memory request.
  task automatic err_chk(input string tag, input logic we, input logic [2:0] op, input logic [31:0] a);
    issue(we, op, a, 32'hFFFFFFFF);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd1);
    chk({tag, " resp_rdata"}, bus.resp_rdata, 32'h0);
    chk({tag, " no_mem_req"}, 32'(bus.mem_req), 32'd0);
    tick();
    chk({tag, " no_mem_req2"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int waited;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_memop  = 3'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    tick();
    tick();
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    tick();

    store_chk("sw", 3'b010, 32'h00000100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    store_chk("sb", 3'b000, 32'h00000103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    store_chk("sh", 3'b001, 32'h00000102, 32'h00001234, 4'b1100, 32'h12341234);
    store_chk("sb1", 3'b000, 32'h00000201, 32'h1122337E, 4'b0010, 32'h7E7E7E7E);

    load_chk("lb", 3'b000, 32'h00000203, 32'h80FF7F01, 32'hFFFFFF80);
    load_chk("lbu", 3'b011, 32'h00000203, 32'h80FF7F01, 32'h00000080);
    load_chk("lh", 3'b001, 32'h00000200, 32'h80FF7F01, 32'h00007F01);
    load_chk("lhu", 3'b100, 32'h00000202, 32'h80FF7F01, 32'h000080FF);
    load_chk("lh_hi", 3'b001, 32'h00000202, 32'h80FF7F01, 32'hFFFF80FF);
    load_chk("lb1", 3'b000, 32'h00000201, 32'h80FF7F01, 32'h0000007F);
    load_chk("lw", 3'b010, 32'h00000200, 32'h80FF7F01, 32'h80FF7F01);

    err_chk("lw_mis", 1'b0, 3'b010, 32'h00000102);
    err_chk("lh_mis", 1'b0, 3'b001, 32'h00000101);
    err_chk("st_op3", 1'b1, 3'b011, 32'h00000100);
    err_chk("ld_op5", 1'b0, 3'b101, 32'h00000100);

    // Grant withheld: the request is held for TIMEOUT cycles then abandoned.
    issue(1'b1, 3'b010, 32'h00000040, 32'h01020304);
    waited = 0;
    while (!bus.resp_valid && waited < 20) begin
      chk("tmo req_held", 32'(bus.mem_req), 32'd1);
      tick();
      waited++;
    end
    chk("tmo cycles", 32'(waited), 32'd4);
    chk("tmo resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("tmo resp_err", 32'(bus.resp_err), 32'd1);
    chk("tmo req_dropped", 32'(bus.mem_req), 32'd0);
    tick();
    chk("tmo ready_idle", 32'(bus.req_ready), 32'd1);
    store_chk("post_tmo", 3'b010, 32'h00000044, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // Reset while waiting for read data; late rvalid must not produce a response.
    issue(1'b0, 3'b010, 32'h00000300, 32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid mem_be", 32'(bus.mem_be), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rst_mid late_rvalid", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("rst_mid late_rvalid2", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid ready2", 32'(bus.req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
